// File: rtl/bios_arb_pkg.sv
// Shared types and constants for the BIOS / XT-IDE ROM arbiter.
package bios_arb_pkg;

  localparam int unsigned BIOS_AW_DEF  = 16;
  localparam int unsigned XTIDE_AW_DEF = 14;
  localparam int unsigned ADDR_W       = 16;
  localparam int unsigned DATA_W       = 8;

  localparam logic TGT_BIOS  = 1'b0;
  localparam logic TGT_XTIDE = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DATA  = 2'd2,
    WR       = 2'd3
  } arb_state_e;

endpackage

// File: rtl/bios_rom_arbiter.sv
// Shares the BIOS and XT-IDE ROM block RAMs between CPU reads and ioctl download writes.
// Optional download checksum on dl_sum is built only when BIOS_DL_CHECKSUM_EN is defined.
module bios_rom_arbiter
  import bios_arb_pkg::*;
#(
  parameter int unsigned BIOS_AW  = BIOS_AW_DEF,
  parameter int unsigned XTIDE_AW = XTIDE_AW_DEF
) (
  input  logic              clka,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_sel,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic              dl_target,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [DATA_W-1:0] dl_data,
  output logic              dl_wait,
  output logic              dl_overrun,
  output logic [DATA_W-1:0] dl_sum,
  output logic              bios_ena,
  output logic              xtide_ena,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dina,
  input  logic [DATA_W-1:0] bios_douta,
  input  logic [DATA_W-1:0] xtide_douta
);

  arb_state_e        state_q;
  logic              rd_sel_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic              cpu_ack_q;
  logic              hold_full_q;
  logic              hold_tgt_q;
  logic [ADDR_W-1:0] hold_addr_q;
  logic [DATA_W-1:0] hold_data_q;
  logic              overrun_q;

  // Zero-extend the address to the width of the selected RAM.
  function automatic logic [ADDR_W-1:0] ram_addr_of(input logic tgt, input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    r = '0;
    if (tgt == TGT_XTIDE) begin
      r[XTIDE_AW-1:0] = a[XTIDE_AW-1:0];
    end else begin
      r[BIOS_AW-1:0] = a[BIOS_AW-1:0];
    end
    return r;
  endfunction

  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rd_sel_q    <= TGT_BIOS;
      rd_addr_q   <= '0;
      cpu_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      hold_full_q <= 1'b0;
      hold_tgt_q  <= TGT_BIOS;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      cpu_ack_q <= 1'b0;

      if (dl_wr) begin
        if (hold_full_q) begin
          overrun_q <= 1'b1;
        end else begin
          hold_full_q <= 1'b1;
          hold_tgt_q  <= dl_target;
          hold_addr_q <= dl_addr;
          hold_data_q <= dl_data;
        end
      end

      case (state_q)
        IDLE: begin
          if (hold_full_q) begin
            state_q <= WR;
          end else if (cpu_req && !dl_active) begin
            rd_sel_q  <= cpu_sel;
            rd_addr_q <= cpu_addr;
            state_q   <= RD_ISSUE;
          end
        end
        RD_ISSUE: state_q <= RD_DATA;
        RD_DATA: begin
          cpu_rdata_q <= (rd_sel_q == TGT_XTIDE) ? xtide_douta : bios_douta;
          cpu_ack_q   <= 1'b1;
          state_q     <= IDLE;
        end
        WR: begin
          // Overrides a capture attempt above: a strobe while full is dropped.
          hold_full_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    bios_ena  = 1'b0;
    xtide_ena = 1'b0;
    ram_wea   = 1'b0;
    ram_addr  = '0;
    ram_dina  = '0;
    case (state_q)
      RD_ISSUE: begin
        bios_ena  = (rd_sel_q == TGT_BIOS);
        xtide_ena = (rd_sel_q == TGT_XTIDE);
        ram_addr  = ram_addr_of(rd_sel_q, rd_addr_q);
      end
      WR: begin
        bios_ena  = (hold_tgt_q == TGT_BIOS);
        xtide_ena = (hold_tgt_q == TGT_XTIDE);
        ram_wea   = 1'b1;
        ram_addr  = ram_addr_of(hold_tgt_q, hold_addr_q);
        ram_dina  = hold_data_q;
      end
      default: ;
    endcase
  end

  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_ack    = cpu_ack_q;
  assign dl_wait    = hold_full_q;
  assign dl_overrun = overrun_q;

`ifdef BIOS_DL_CHECKSUM_EN
  logic              dl_active_q;
  logic [DATA_W-1:0] sum_q;

  // A new download session restarts the sum, even if a write lands in the same cycle.
  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) begin
      dl_active_q <= 1'b0;
      sum_q       <= '0;
    end else begin
      dl_active_q <= dl_active;
      if (dl_active && !dl_active_q) begin
        sum_q <= '0;
      end else if (state_q == WR) begin
        sum_q <= sum_q + ram_dina;
      end
    end
  end

  assign dl_sum = sum_q;
`else
  assign dl_sum = '0;
`endif

  a_ena_exclusive: assert property (@(posedge clka) disable iff (!reset_n)
    !(bios_ena && xtide_ena));
  a_dina_only_in_wr: assert property (@(posedge clka) disable iff (!reset_n)
    (state_q != WR) |-> (ram_dina == '0));

endmodule

// File: tb/tb_bios_rom_arbiter.sv
// Directed bench for bios_rom_arbiter with behavioural single-port RAM models.
module tb_bios_rom_arbiter;

  logic        clka;
  logic        reset_n;
  logic        cpu_req;
  logic        cpu_sel;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        dl_active;
  logic        dl_wr;
  logic        dl_target;
  logic [15:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wait;
  logic        dl_overrun;
  logic [7:0]  dl_sum;
  logic        bios_ena;
  logic        xtide_ena;
  logic        ram_wea;
  logic [15:0] ram_addr;
  logic [7:0]  ram_dina;
  logic [7:0]  bios_douta;
  logic [7:0]  xtide_douta;

  logic [7:0]  bios_mem [65536];
  logic [7:0]  xtide_mem [16384];

  int tests;
  int fails;

  bios_rom_arbiter dut (
    .clka        (clka),
    .reset_n     (reset_n),
    .cpu_req     (cpu_req),
    .cpu_sel     (cpu_sel),
    .cpu_addr    (cpu_addr),
    .cpu_rdata   (cpu_rdata),
    .cpu_ack     (cpu_ack),
    .dl_active   (dl_active),
    .dl_wr       (dl_wr),
    .dl_target   (dl_target),
    .dl_addr     (dl_addr),
    .dl_data     (dl_data),
    .dl_wait     (dl_wait),
    .dl_overrun  (dl_overrun),
    .dl_sum      (dl_sum),
    .bios_ena    (bios_ena),
    .xtide_ena   (xtide_ena),
    .ram_wea     (ram_wea),
    .ram_addr    (ram_addr),
    .ram_dina    (ram_dina),
    .bios_douta  (bios_douta),
    .xtide_douta (xtide_douta)
  );

  initial begin
    clka = 1'b0;
    forever #5 clka = ~clka;
  end

  always_ff @(posedge clka) begin
    if (bios_ena) begin
      if (ram_wea) bios_mem[ram_addr] <= ram_dina;
      else         bios_douta <= bios_mem[ram_addr];
    end
    if (xtide_ena) begin
      if (ram_wea) xtide_mem[ram_addr[13:0]] <= ram_dina;
      else         xtide_douta <= xtide_mem[ram_addr[13:0]];
    end
  end

  task automatic tick;
    @(posedge clka);
    #1;
  endtask

  // Issues one CPU read and waits (bounded) for the ack; lat = -1 on timeout.
  task automatic cpu_read(input logic sel, input logic [15:0] addr,
                          output logic [7:0] data, output int lat);
    cpu_sel  = sel;
    cpu_addr = addr;
    cpu_req  = 1'b1;
    lat      = 0;
    data     = 8'h00;
    while (!cpu_ack && lat < 30) begin
      tick();
      lat++;
    end
    if (!cpu_ack) lat = -1;
    data    = cpu_rdata;
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    tests++;
    if ({cpu_rdata, cpu_ack, dl_wait, dl_overrun, dl_sum} !== 19'h0) begin
      fails++;
      $display("FAIL reset_status got %h want 0", {cpu_rdata, cpu_ack, dl_wait, dl_overrun, dl_sum});
    end
    tests++;
    if ({bios_ena, xtide_ena, ram_wea, ram_addr, ram_dina} !== 27'h0) begin
      fails++;
      $display("FAIL reset_ram got %h want 0", {bios_ena, xtide_ena, ram_wea, ram_addr, ram_dina});
    end
  endtask

  task automatic test_cpu_read_bios;
    logic xt_seen;
    xt_seen  = 1'b0;
    cpu_sel  = 1'b0;
    cpu_addr = 16'hFFF0;
    cpu_req  = 1'b1;
    tick();
    xt_seen |= xtide_ena;
    tests++;
    if ({bios_ena, ram_wea, ram_addr} !== {1'b1, 1'b0, 16'hFFF0}) begin
      fails++;
      $display("FAIL rd_issue got ena=%b wea=%b addr=%h want 1 0 fff0", bios_ena, ram_wea, ram_addr);
    end
    tick();
    xt_seen |= xtide_ena;
    tests++;
    if (cpu_ack !== 1'b0) begin
      fails++;
      $display("FAIL rd_early_ack got %b want 0", cpu_ack);
    end
    tick();
    xt_seen |= xtide_ena;
    tests++;
    if ({cpu_ack, cpu_rdata} !== {1'b1, 8'hEA}) begin
      fails++;
      $display("FAIL rd_ack got ack=%b data=%h want 1 ea", cpu_ack, cpu_rdata);
    end
    cpu_req = 1'b0;
    tick();
    xt_seen |= xtide_ena;
    tests++;
    if ({cpu_ack, cpu_rdata} !== {1'b0, 8'hEA}) begin
      fails++;
      $display("FAIL rd_hold got ack=%b data=%h want 0 ea", cpu_ack, cpu_rdata);
    end
    tests++;
    if (xt_seen !== 1'b0) begin
      fails++;
      $display("FAIL rd_xtide_quiet got %b want 0", xt_seen);
    end
  endtask

  task automatic test_download;
    logic [7:0] d;
    int         lat;
    dl_active = 1'b1;
    dl_wr     = 1'b1;
    dl_target = 1'b1;
    dl_addr   = 16'h0123;
    dl_data   = 8'h5A;
    tick();
    dl_wr = 1'b0;
    tests++;
    if ({dl_wait, xtide_ena} !== 2'b10) begin
      fails++;
      $display("FAIL dl_wait_set got wait=%b ena=%b want 1 0", dl_wait, xtide_ena);
    end
    tick();
    tests++;
    if ({xtide_ena, bios_ena, ram_wea, ram_addr, ram_dina} !== {3'b101, 16'h0123, 8'h5A}) begin
      fails++;
      $display("FAIL dl_wr_cycle got %b%b%b %h %h want 101 0123 5a",
               xtide_ena, bios_ena, ram_wea, ram_addr, ram_dina);
    end
    tick();
    tests++;
    if ({dl_wait, xtide_ena, ram_dina} !== 10'h0) begin
      fails++;
      $display("FAIL dl_after_wr got wait=%b ena=%b dina=%h want 0 0 00", dl_wait, xtide_ena, ram_dina);
    end
    dl_active = 1'b0;
    cpu_read(1'b1, 16'h0123, d, lat);
    tests++;
    if (d !== 8'h5A || lat != 3) begin
      fails++;
      $display("FAIL dl_readback got data=%h lat=%0d want 5a 3", d, lat);
    end
  endtask

  task automatic test_dl_priority;
    int acks;
    int lat;
    acks      = 0;
    dl_active = 1'b1;
    cpu_sel   = 1'b0;
    cpu_addr  = 16'h1000;
    cpu_req   = 1'b1;
    repeat (20) begin
      tick();
      if (cpu_ack) acks++;
    end
    tests++;
    if (acks != 0) begin
      fails++;
      $display("FAIL prio_blocked got %0d acks want 0", acks);
    end
    dl_wr     = 1'b1;
    dl_target = 1'b0;
    dl_addr   = 16'h1000;
    dl_data   = 8'h77;
    tick();
    dl_wr     = 1'b0;
    dl_active = 1'b0;
    tick();
    tests++;
    if ({bios_ena, ram_wea, ram_addr, ram_dina} !== {2'b11, 16'h1000, 8'h77}) begin
      fails++;
      $display("FAIL prio_wr_first got %b%b %h %h want 11 1000 77", bios_ena, ram_wea, ram_addr, ram_dina);
    end
    tick();
    tests++;
    if ({bios_ena, ram_wea} !== 2'b00) begin
      fails++;
      $display("FAIL prio_idle got ena=%b wea=%b want 0 0", bios_ena, ram_wea);
    end
    lat = 0;
    while (!cpu_ack && lat < 10) begin
      tick();
      lat++;
    end
    tests++;
    if (lat != 3 || cpu_rdata !== 8'h77) begin
      fails++;
      $display("FAIL prio_read got lat=%0d data=%h want 3 77", lat, cpu_rdata);
    end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_overrun;
    logic [7:0] d;
    int         lat;
    dl_active = 1'b1;
    dl_wr     = 1'b1;
    dl_target = 1'b0;
    dl_addr   = 16'h2000;
    dl_data   = 8'h11;
    tick();
    dl_addr = 16'h2001;
    dl_data = 8'h22;
    tick();
    dl_wr = 1'b0;
    tests++;
    if ({dl_overrun, ram_wea, ram_addr, ram_dina} !== {2'b11, 16'h2000, 8'h11}) begin
      fails++;
      $display("FAIL ovr_set got ovr=%b wea=%b %h %h want 1 1 2000 11",
               dl_overrun, ram_wea, ram_addr, ram_dina);
    end
    repeat (3) tick();
    tests++;
    if ({dl_overrun, dl_wait} !== 2'b10) begin
      fails++;
      $display("FAIL ovr_sticky got ovr=%b wait=%b want 1 0", dl_overrun, dl_wait);
    end
    dl_active = 1'b0;
    cpu_read(1'b0, 16'h2001, d, lat);
    tests++;
    if (d !== 8'hC3) begin
      fails++;
      $display("FAIL ovr_dropped got %h want c3", d);
    end
    cpu_read(1'b0, 16'h2000, d, lat);
    tests++;
    if (d !== 8'h11 || dl_overrun !== 1'b1) begin
      fails++;
      $display("FAIL ovr_first_kept got %h ovr=%b want 11 1", d, dl_overrun);
    end
  endtask

  task automatic test_checksum;
    logic [7:0] bytes [3];
    bytes[0] = 8'hFF;
    bytes[1] = 8'h02;
    bytes[2] = 8'h10;
    dl_active = 1'b0;
    tick();
    dl_active = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      dl_wr     = 1'b1;
      dl_target = 1'b0;
      dl_addr   = 16'h3000 + 16'(i);
      dl_data   = bytes[i];
      tick();
      dl_wr = 1'b0;
      tick();
      tick();
    end
`ifdef BIOS_DL_CHECKSUM_EN
    tests++;
    if (dl_sum !== 8'h11) begin
      fails++;
      $display("FAIL sum_value got %h want 11", dl_sum);
    end
    dl_active = 1'b0;
    tick();
    dl_active = 1'b1;
    tick();
    tests++;
    if (dl_sum !== 8'h00) begin
      fails++;
      $display("FAIL sum_clear got %h want 00", dl_sum);
    end
`else
    tests++;
    if (dl_sum !== 8'h00) begin
      fails++;
      $display("FAIL sum_disabled got %h want 00", dl_sum);
    end
`endif
    dl_active = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_read;
    int acks;
    int wrs;
    cpu_sel   = 1'b1;
    cpu_addr  = 16'h0123;
    cpu_req   = 1'b1;
    dl_wr     = 1'b1;
    dl_target = 1'b0;
    dl_addr   = 16'h4000;
    dl_data   = 8'h99;
    tick();
    dl_wr = 1'b0;
    tests++;
    if ({xtide_ena, dl_wait} !== 2'b11) begin
      fails++;
      $display("FAIL rst_setup got ena=%b wait=%b want 1 1", xtide_ena, dl_wait);
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if ({bios_ena, xtide_ena, ram_wea, ram_addr, ram_dina, cpu_ack, cpu_rdata,
         dl_wait, dl_overrun, dl_sum} !== 46'h0) begin
      fails++;
      $display("FAIL rst_outputs got ena=%b%b wea=%b addr=%h ack=%b rdata=%h wait=%b ovr=%b want all 0",
               bios_ena, xtide_ena, ram_wea, ram_addr, cpu_ack, cpu_rdata, dl_wait, dl_overrun);
    end
    cpu_req = 1'b0;
    tick();
    reset_n = 1'b1;
    acks = 0;
    wrs  = 0;
    repeat (8) begin
      tick();
      if (cpu_ack) acks++;
      if (ram_wea) wrs++;
    end
    tests++;
    if (acks != 0 || wrs != 0 || dl_wait !== 1'b0) begin
      fails++;
      $display("FAIL rst_aftermath got acks=%0d wrs=%0d wait=%b want 0 0 0", acks, wrs, dl_wait);
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    reset_n   = 1'b0;
    cpu_req   = 1'b0;
    cpu_sel   = 1'b0;
    cpu_addr  = '0;
    dl_active = 1'b0;
    dl_wr     = 1'b0;
    dl_target = 1'b0;
    dl_addr   = '0;
    dl_data   = '0;
    bios_douta  = '0;
    xtide_douta = '0;
    bios_mem[16'hFFF0] = 8'hEA;
    bios_mem[16'h2001] = 8'hC3;
    #3;
    test_reset();
    tick();
    reset_n = 1'b1;
    test_cpu_read_bios();
    test_download();
    test_dl_priority();
    test_overrun();
    test_checksum();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/bios_rom_arbiter.md
Name: bios_rom_arbiter

Overview:
Sequences the shared single-port BIOS (64 KiB) and XT-IDE option ROM (16 KiB) block RAMs between two requesters.
- The CPU bus issues reads.
- The host download stream (ioctl) issues writes while loading ROM images.
- Provides a one-entry download hold buffer with back-pressure.
- Download has priority over CPU reads.

Parameters:
BIOS_AW, 16, BIOS RAM address width
XTIDE_AW, 14, XT-IDE RAM address width

Ports:
clka  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
cpu_req  in  1  CPU read request, level, held until cpu_ack
cpu_sel  in  1  0=BIOS, 1=XT-IDE
cpu_addr  in  16  CPU byte address (XT-IDE uses [13:0])
cpu_rdata  out  8  read data, valid while cpu_ack=1, held afterwards
cpu_ack  out  1  one-cycle completion pulse
dl_active  in  1  download in progress; blocks CPU acceptance
dl_wr  in  1  one-cycle write strobe
dl_target  in  1  0=BIOS, 1=XT-IDE
dl_addr  in  16  download byte address
dl_data  in  8  download byte
dl_wait  out  1  hold buffer full; source must not strobe
dl_overrun  out  1  sticky: dl_wr arrived while hold full
dl_sum  out  8  download checksum (see Optional Feature)
bios_ena  out  1  BIOS RAM enable
xtide_ena  out  1  XT-IDE RAM enable
ram_wea  out  1  shared write enable
ram_addr  out  16  shared address
ram_dina  out  8  shared write data
bios_douta  in  8  BIOS RAM registered read data (1-cycle latency)
xtide_douta  in  8  XT-IDE RAM registered read data

Behaviour:
- Reset (async, reset_n=0):
  - State is IDLE.
  - The hold buffer is empty.
  - All outputs are 0, including cpu_rdata, dl_overrun and dl_sum.
- FSM states are IDLE, RD_ISSUE, RD_DATA, WR. RAM control outputs are decoded from the registered state and latched address, target and data.
- IDLE decision, evaluated on registered values:
  - If the hold buffer is full, go to WR.
  - Else if cpu_req=1 and dl_active=0, latch cpu_sel and cpu_addr, then go to RD_ISSUE (the accept cycle is T).
  - Else stay in IDLE.
- RD_ISSUE (T+1):
  - Assert the selected enable, ram_wea=0, ram_addr=latched address.
  - Next state is RD_DATA.
- RD_DATA (T+2):
  - Register the selected douta into cpu_rdata.
  - Set cpu_ack=1 for cycle T+3.
  - Next state is IDLE.
  - Read latency is cpu_ack at T+3. The requester drops cpu_req in the cycle cpu_ack is seen; the next accept is T+3 at earliest.
- WR (one cycle):
  - Assert the selected enable, ram_wea=1, with ram_addr and ram_dina taken from the hold buffer.
  - The hold buffer empties at the end of the cycle; next state is IDLE.
  - dl_wait is low from the following cycle.
- Hold buffer:
  - Captures dl_target, dl_addr and dl_data on any dl_wr while empty.
  - dl_wait = buffer full.
  - A dl_wr while full drops the byte and sets dl_overrun (sticky until reset).
- Simultaneous events:
  - dl_wr and cpu_req in IDLE with the buffer empty and dl_active=0: the CPU read is accepted and the byte is captured; the write follows after the read returns.
  - A dl_wr arriving during a read is captured and written after RD_DATA.
- dl_active:
  - Rising high never aborts an in-flight read.
  - Falling low does not skip a pending write; the write completes before any CPU acceptance.
- Inactive outputs: bios_ena and xtide_ena are never both high. Both are low in IDLE. ram_dina is 0 outside WR.
- Reset mid-operation aborts any read without cpu_ack and discards the held byte.

Optional Feature:
Macro BIOS_DL_CHECKSUM_EN.
- Defined:
  - dl_sum accumulates ram_dina modulo 256 on every WR cycle.
  - dl_sum clears to 0 on the dl_active rising edge, detected with a registered copy of dl_active.
- Undefined:
  - dl_sum is tied to 0 and no accumulator or edge register is built.
  - The port list is unchanged.

Decomposition:
- Package bios_arb_pkg holds:
  - the FSM state enum (IDLE, RD_ISSUE, RD_DATA, WR);
  - target constants TGT_BIOS=1'b0 and TGT_XTIDE=1'b1;
  - the width constants.
- No sub-module is needed. The hold buffer and FSM are inline.

Test Plan:
1. Reset, dl_active=0, cpu_req=1, cpu_sel=0, cpu_addr=16'hFFF0 with BIOS[FFF0]=8'hEA -> bios_ena=1 at T+1, cpu_ack=1 and cpu_rdata=8'hEA at T+3, xtide_ena never high.
2. dl_active=1, dl_wr with target=1, addr=16'h0123, data=8'h5A -> dl_wait=1 next cycle, xtide_ena=1, ram_wea=1, ram_addr=16'h0123 in WR, dl_wait=0 after; a subsequent CPU read of XT-IDE 0123 returns 8'h5A.
3. dl_active=1, cpu_req=1 held for 20 cycles -> no cpu_ack. Drop dl_active with a byte pending -> WR occurs first, then the read is accepted and acked 3 cycles later.
4. Two dl_wr strobes on consecutive cycles while full -> the second byte is not written and dl_overrun=1 until reset.
5. With BIOS_DL_CHECKSUM_EN: download bytes 8'hFF, 8'h02, 8'h10 -> dl_sum=8'h11. A new dl_active rise -> dl_sum=0.
6. Assert reset_n=0 during RD_ISSUE -> all outputs 0 immediately, no cpu_ack after release, hold buffer empty (dl_wait=0).
